// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32 R-type decode, regfile read, scoreboard issue.
// Option ALU_ISSUE_ILLEGAL_TRAP_EN: consume illegal words without issue.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val,
  output logic [4:0]  alu_control,
  output logic [4:0]  rd_addr,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        illegal_flag
);

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  op;
    logic [4:0]  rd;
  } bundle_t;

  logic [31:0] rf_q [32];
  logic [31:0] pend_q, pend_d;
  logic        vld_q, vld_d;
  bundle_t     bnd_q, bnd_d;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [9:0]  key;
  logic        opc_ok;
  logic [4:0]  op;

  assign opc = instr[6:0];
  assign rd  = instr[11:7];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign f7  = instr[31:25];
  assign key = {f7, f3};
  assign opc_ok = (opc == 7'b0110011);

  always_comb begin
    op = 5'd0;
    unique case (1'b1)
      key == 10'b0000000_000: op = 5'd1;
      key == 10'b0100000_000: op = 5'd2;
      key == 10'b0000000_100: op = 5'd3;
      key == 10'b0000000_110: op = 5'd4;
      key == 10'b0000000_111: op = 5'd5;
      key == 10'b0000000_001: op = 5'd6;
      key == 10'b0000000_101: op = 5'd7;
      default:                op = 5'd0;
    endcase
    if (!opc_ok) op = 5'd0;
  end

  logic [31:0] clr, live, set;
  logic        hazard, accept, issue;

  // A bit retiring this cycle no longer blocks.
  assign clr    = wb_valid ? (32'd1 << wb_addr) : 32'd0;
  assign live   = pend_q & ~clr;
  assign hazard = live[rs1] | live[rs2] | live[rd];

  assign instr_ready = (~vld_q | out_ready) & ~hazard;
  assign accept      = instr_valid & instr_ready;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic legal;
  logic ill_q;
  assign legal = (op != 5'd0);
  assign issue = accept & legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ill_q <= 1'b0;
    else if (accept && !legal) ill_q <= 1'b1;
  end

  assign illegal_flag = ill_q;
`else
  assign issue        = accept;
  assign illegal_flag = 1'b0;
`endif

  assign set    = (issue && rd != 5'd0) ? (32'd1 << rd) : 32'd0;
  assign pend_d = (live | set) & ~32'd1;

  logic [31:0] op1, op2;

  always_comb begin
    op1 = rf_q[rs1];
    if (rs1 == 5'd0) op1 = 32'd0;
    else if (wb_valid && wb_addr == rs1) op1 = wb_data;
    op2 = rf_q[rs2];
    if (rs2 == 5'd0) op2 = 32'd0;
    else if (wb_valid && wb_addr == rs2) op2 = wb_data;
  end

  always_comb begin
    bnd_d = bnd_q;
    vld_d = vld_q;
    if (issue) begin
      bnd_d = '{rs1: op1, rs2: op2, op: op, rd: rd};
      vld_d = 1'b1;
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      bnd_q  <= '0;
      pend_q <= '0;
    end else begin
      vld_q  <= vld_d;
      bnd_q  <= bnd_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_valid && wb_addr != 5'd0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign out_valid   = vld_q;
  assign rs1_val     = bnd_q.rs1;
  assign rs2_val     = bnd_q.rs2;
  assign alu_control = bnd_q.op;
  assign rd_addr     = bnd_q.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: vector table, directed corners and random traffic
// checked against a register/scoreboard reference model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        out_ready = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        instr_ready, out_valid, illegal_flag;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  alu_control, rd_addr;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .alu_control(alu_control), .rd_addr(rd_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal_flag(illegal_flag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // {funct7, funct3} for codes 1..7 in order
  logic [9:0] ops [7] = '{10'b0000000000, 10'b0100000000,
    10'b0000000100, 10'b0000000110, 10'b0000000111,
    10'b0000000001, 10'b0000000101};

  logic [31:0] m_rf [32];
  bit          m_pend [32];
  bit          m_ov, m_ill;
  logic [31:0] m_r1, m_r2;
  logic [4:0]  m_op, m_rd;

  function automatic logic [31:0] enc(input logic [6:0] f7,
    input logic [4:0] s2, input logic [4:0] s1,
    input logic [2:0] f3, input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [4:0] mdec(input logic [31:0] w);
    if (w[6:0] != 7'b0110011) return 5'd0;
    for (int i = 0; i < 7; i++)
      if ({w[31:25], w[14:12]} == ops[i]) return 5'(i + 1);
    return 5'd0;
  endfunction

  function automatic logic [31:0] mval(input logic [4:0] idx,
    input bit wbv, input logic [4:0] wba, input logic [31:0] wbd);
    if (idx == 0) return 32'd0;
    if (wbv && wba == idx) return wbd;
    return m_rf[idx];
  endfunction

  function automatic bit mbusy(input logic [4:0] idx, input bit wbv,
                               input logic [4:0] wba);
    return idx != 0 && m_pend[idx] && !(wbv && wba == idx);
  endfunction

  task automatic mreset();
    for (int i = 0; i < 32; i++) begin
      m_rf[i] = 0;
      m_pend[i] = 0;
    end
    m_ov = 0; m_ill = 0;
    m_r1 = 0; m_r2 = 0; m_op = 0; m_rd = 0;
  endtask

  task automatic cycle(input bit iv, input logic [31:0] w,
    input bit ordy, input bit wbv, input logic [4:0] wba,
    input logic [31:0] wbd, output bit acc);
    bit rdy, iss;
    logic [4:0] code;
    @(negedge clk);
    instr_valid = iv; instr = w; out_ready = ordy;
    wb_valid = wbv; wb_addr = wba; wb_data = wbd;
    #1;
    rdy = (!m_ov || ordy) && !(mbusy(w[19:15], wbv, wba) ||
          mbusy(w[24:20], wbv, wba) || mbusy(w[11:7], wbv, wba));
    chk("instr_ready", instr_ready, rdy);
    acc = iv && rdy;
    code = mdec(w);
    iss = acc;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    iss = acc && code != 0;
    if (acc && code == 0) m_ill = 1;
`endif
    if (iss) begin
      m_r1 = mval(w[19:15], wbv, wba, wbd);
      m_r2 = mval(w[24:20], wbv, wba, wbd);
      m_op = code;
      m_rd = w[11:7];
    end
    if (wbv) begin
      if (wba != 0) m_rf[wba] = wbd;
      m_pend[wba] = 0;
    end
    if (iss && w[11:7] != 0) m_pend[w[11:7]] = 1;
    m_ov = iss ? 1'b1 : (ordy ? 1'b0 : m_ov);
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("rs1_val", rs1_val, m_r1);
    chk("rs2_val", rs2_val, m_r2);
    chk("alu_control", alu_control, m_op);
    chk("rd_addr", rd_addr, m_rd);
    chk("illegal_flag", illegal_flag, m_ill);
  endtask

  task automatic idle_wb(input logic [4:0] a, input logic [31:0] d);
    bit x;
    cycle(0, 32'd0, 1, 1, a, d, x);
  endtask

  typedef struct {
    string       nm;
    logic [31:0] w;
    logic [4:0]  code;
  } vec_t;

  vec_t vt [10];

  initial begin
    bit a;
    logic [31:0] w;
    vt[0] = '{"add", enc(7'h00, 2, 1, 3'd0, 0), 5'd1};
    vt[1] = '{"sub", 32'h40208033, 5'd2};
    vt[2] = '{"xor", enc(7'h00, 2, 1, 3'd4, 0), 5'd3};
    vt[3] = '{"or",  enc(7'h00, 2, 1, 3'd6, 0), 5'd4};
    vt[4] = '{"and", enc(7'h00, 2, 1, 3'd7, 0), 5'd5};
    vt[5] = '{"sll", enc(7'h00, 2, 1, 3'd1, 0), 5'd6};
    vt[6] = '{"srl", enc(7'h00, 2, 1, 3'd5, 0), 5'd7};
    vt[7] = '{"mul", enc(7'h01, 2, 1, 3'd0, 0), 5'd0};
    vt[8] = '{"sra", enc(7'h20, 2, 1, 3'd5, 0), 5'd0};
    vt[9] = '{"slt", enc(7'h00, 2, 1, 3'd2, 0), 5'd0};

    mreset();
    #12;
    chk("rst out_valid", out_valid, 0);
    chk("rst alu_control", alu_control, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst instr_ready", instr_ready, 1);

    cycle(0, 32'd0, 1, 0, 0, 0, a);
    chk("idle out_valid", out_valid, 0);
    chk("idle rs1_val", rs1_val, 0);

    idle_wb(1, 5);
    idle_wb(2, 3);
    cycle(1, 32'h402081B3, 1, 0, 0, 0, a);
    chk("sub acc", a, 1);
    chk("sub rs1", rs1_val, 5);
    chk("sub rs2", rs2_val, 3);
    chk("sub op", alu_control, 2);
    chk("sub rd", rd_addr, 3);
    idle_wb(3, 2);

    cycle(1, enc(7'h00, 2, 1, 3'd0, 3), 1, 0, 0, 0, a);
    chk("raw add acc", a, 1);
    w = enc(7'h00, 1, 3, 3'd7, 5);
    for (int i = 0; i < 2; i++) begin
      cycle(1, w, 1, 0, 0, 0, a);
      chk("raw stall", a, 0);
    end
    cycle(1, w, 1, 1, 3, 8, a);
    chk("raw acc", a, 1);
    chk("raw bypass", rs1_val, 8);
    chk("raw op", alu_control, 5);

    cycle(1, enc(7'h00, 2, 1, 3'd0, 6), 1, 0, 0, 0, a);
    chk("bp first", a, 1);
    w = enc(7'h00, 2, 1, 3'd0, 7);
    for (int i = 0; i < 4; i++) begin
      cycle(1, w, 0, 0, 0, 0, a);
      chk("bp stall", a, 0);
      chk("bp rd stable", rd_addr, 6);
      chk("bp rs1 stable", rs1_val, 5);
    end
    cycle(1, w, 1, 0, 0, 0, a);
    chk("bp release", a, 1);
    chk("bp rd", rd_addr, 7);
    idle_wb(5, 1);
    idle_wb(6, 2);
    idle_wb(7, 3);

    w = enc(7'h00, 0, 0, 3'd0, 0);
    cycle(1, w, 1, 1, 0, 32'hFFFFFFFF, a);
    chk("x0 acc", a, 1);
    chk("x0 no bypass", rs1_val, 0);
    cycle(1, w, 1, 0, 0, 0, a);
    chk("x0 no stall", a, 1);
    chk("x0 read", rs2_val, 0);

    cycle(1, 32'h00000013, 1, 0, 0, 0, a);
    chk("ill acc", a, 1);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    chk("ill no issue", out_valid, 0);
    chk("ill flag", illegal_flag, 1);
`else
    chk("ill issue", out_valid, 1);
    chk("ill op", alu_control, 0);
    chk("ill flag", illegal_flag, 0);
`endif

    for (int i = 0; i < 10; i++) begin
      cycle(1, vt[i].w, 1, 0, 0, 0, a);
      chk({"vec acc ", vt[i].nm}, a, 1);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      chk({"vec valid ", vt[i].nm}, out_valid, vt[i].code != 0);
      if (vt[i].code != 0)
        chk({"vec op ", vt[i].nm}, alu_control, vt[i].code);
`else
      chk({"vec op ", vt[i].nm}, alu_control, vt[i].code);
`endif
    end

    for (int i = 0; i < 400; i++) begin
      bit iv, ordy, wbv;
      logic [4:0] wba;
      iv   = ($urandom % 4) != 0;
      ordy = ($urandom % 4) != 0;
      wbv  = ($urandom % 3) == 0;
      wba  = 5'($urandom % 8);
      if ($urandom % 8 == 0) w = $urandom;
      else w = {ops[$urandom % 7][9:3], 5'($urandom % 8),
                5'($urandom % 8), ops[$urandom % 7][2:0],
                5'($urandom % 8), 7'b0110011};
      cycle(iv, w, ordy, wbv, wba, $urandom, a);
    end

    cycle(1, enc(7'h00, 2, 1, 3'd0, 9), 1, 1, 1, 32'h77, a);
    #2;
    rst_n = 1'b0;
    instr_valid = 0; wb_valid = 0; out_ready = 0;
    #1;
    mreset();
    chk("mid rst out_valid", out_valid, 0);
    chk("mid rst rd_addr", rd_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, enc(7'h00, 2, 1, 3'd0, 9), 1, 0, 0, 0, a);
    chk("post rst acc", a, 1);
    chk("post rst x1", rs1_val, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
